// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      F3_MUL    = 3'd0,
      F3_MULH   = 3'd1,
      F3_MULHSU = 3'd2,
      F3_MULHU  = 3'd3,
      F3_DIV    = 3'd4,
      F3_DIVU   = 3'd5,
      F3_REM    = 3'd6,
      F3_REMU   = 3'd7
   } op_e;

   function automatic logic op_is_div(input logic [2:0] f);
      return f[2];
   endfunction

   function automatic logic op_is_rem(input logic [2:0] f);
      return f[2] & f[1];
   endfunction

   function automatic logic op_a_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the pipeline and muldiv_unit.
interface muldiv_unit_if;
   import muldiv_pkg::*;

   logic            start_e;
   logic [2:0]      funct3_e;
   logic [XLEN-1:0] src_a_e;
   logic [XLEN-1:0] src_b_e;
   logic [4:0]      rd_e;
   logic            flush_e;
   logic            stall_req;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output start_e, funct3_e, src_a_e, src_b_e, rd_e, flush_e,
      input  stall_req, done, result, rd_out
   );

   modport slave (
      input  start_e, funct3_e, src_a_e, src_b_e, rd_e, flush_e,
      output stall_req, done, result, rd_out
   );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers, one shift-add or restoring shift-subtract step
// per enable, and the sign fixup of the selected result half.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int unsigned W = XLEN
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         step,
   input  logic [2:0]   ld_op,
   input  logic [W-1:0] ld_a,
   input  logic [W-1:0] ld_b,
   input  logic [2:0]   op,
   output logic [W-1:0] res_c
);

   // hi doubles as product high word (multiply) and remainder (divide);
   // lo doubles as multiplier (multiply) and dividend/quotient (divide).
   logic [W:0]   hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic [W-1:0] opd_q, opd_d;
   logic         neg_q_q, neg_q_d;
   logic         neg_r_q, neg_r_d;

   logic         sign_a, sign_b;
   logic [W-1:0] mag_a, mag_b;
   logic [W:0]   shifted, diff, add;
   logic [2*W-1:0] prod, prod_n;

   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      opd_d   = opd_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      sign_a  = op_a_signed(ld_op) & ld_a[W-1];
      sign_b  = op_b_signed(ld_op) & ld_b[W-1];
      mag_a   = sign_a ? -ld_a : ld_a;
      mag_b   = sign_b ? -ld_b : ld_b;
      shifted = {hi_q[W-1:0], lo_q[W-1]};
      diff    = shifted - {1'b0, opd_q};
      add     = lo_q[0] ? (hi_q + {1'b0, opd_q}) : hi_q;

      if (load) begin
         hi_d    = '0;
         lo_d    = op_is_div(ld_op) ? mag_a : mag_b;
         opd_d   = op_is_div(ld_op) ? mag_b : mag_a;
         neg_q_d = sign_a ^ sign_b;
         neg_r_d = sign_a;
      end else if (step) begin
         if (op_is_div(op)) begin
            // Trial subtract; a clear borrow bit means the quotient bit is 1.
            if (!diff[W]) begin
               hi_d = diff;
               lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
               hi_d = shifted;
               lo_d = {lo_q[W-2:0], 1'b0};
            end
         end else begin
            hi_d = {1'b0, add[W:1]};
            lo_d = {add[0], lo_q[W-1:1]};
         end
      end
   end

   // High-word negation must borrow from the low word, so negate the full product.
   always_comb begin
      prod   = {hi_q[W-1:0], lo_q};
      prod_n = neg_q_q ? -prod : prod;
      res_c  = lo_q;
      case (op)
         F3_MUL:                        res_c = lo_q;
         F3_MULH, F3_MULHSU, F3_MULHU:  res_c = prod_n[2*W-1:W];
         F3_DIV, F3_DIVU:               res_c = neg_q_q ? -lo_q : lo_q;
         default:                       res_c = neg_r_q ? -hi_q[W-1:0] : hi_q[W-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hi_q    <= '0;
         lo_q    <= '0;
         opd_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opd_q   <= opd_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: control FSM, step counter, special-case
// shortcut, pipeline stall request and registered result.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   muldiv_unit_if.slave  mdu
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;

   logic              load_c, step_c, stall_c;
   logic              b_zero_c, ovf_c, special_c;
   logic [XLEN-1:0]   special_val_c, dp_res_c;

   // Divide-by-zero and signed overflow bypass the iteration entirely.
   always_comb begin
      b_zero_c      = (mdu.src_b_e == '0);
      ovf_c         = !mdu.funct3_e[0] && (mdu.src_a_e == INT_MIN) && (mdu.src_b_e == '1);
      special_c     = op_is_div(mdu.funct3_e) && (b_zero_c || ovf_c);
      special_val_c = mdu.src_a_e;
      if (b_zero_c)
         special_val_c = op_is_rem(mdu.funct3_e) ? mdu.src_a_e : '1;
      else
         special_val_c = op_is_rem(mdu.funct3_e) ? '0 : INT_MIN;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      load_c   = 1'b0;
      step_c   = 1'b0;
      stall_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mdu.start_e) begin
               stall_c  = 1'b1;
               funct3_d = mdu.funct3_e;
               rd_d     = mdu.rd_e;
               cnt_d    = '0;
               if (special_c) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  result_d = special_val_c;
                  rd_out_d = mdu.rd_e;
               end else begin
                  state_d = ST_CALC;
                  load_c  = 1'b1;
               end
            end
         end
         ST_CALC: begin
            stall_c = 1'b1;
            step_c  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(XLEN))
               state_d = ST_FIXUP;
         end
         ST_FIXUP: begin
            stall_c  = 1'b1;
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = dp_res_c;
            rd_out_d = rd_q;
         end
         default: state_d = ST_IDLE;
      endcase

      // A flush abandons the op and leaves the previous result visible.
      if (mdu.flush_e) begin
         state_d  = ST_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
         rd_out_d = rd_out_q;
         load_c   = 1'b0;
         step_c   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
      end
   end

   muldiv_datapath #(.W(XLEN)) u_datapath (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_c),
      .step    (step_c),
      .ld_op   (mdu.funct3_e),
      .ld_a    (mdu.src_a_e),
      .ld_b    (mdu.src_b_e),
      .op      (funct3_q),
      .res_c   (dp_res_c)
   );

   assign mdu.stall_req = stall_c;
   assign mdu.done      = done_q;
   assign mdu.result    = result_q;
   assign mdu.rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model checked every cycle.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   muldiv_unit_if bus();

   muldiv_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mdu     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Reference result straight from the RV32M definitions, using 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s;
      logic [63:0] ua, ub, p;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ua   = {32'b0, a};
      ub   = {32'b0, b};
      ub_s = {32'b0, b};
      p    = '0;
      case (f)
         3'd0: begin p = ua * ub;   return p[31:0];  end
         3'd1: begin p = sa * sb;   return p[63:32]; end
         3'd2: begin p = sa * ub_s; return p[63:32]; end
         3'd3: begin p = ua * ub;   return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   // Timing-level model: an accepted op owns the unit for `lat` cycles after acceptance.
   bit          m_valid = 1'b0;
   bit          m_busy  = 1'b0;
   int          m_acc, m_lat;
   logic [31:0] m_res, m_pend;
   logic [4:0]  m_rd, m_pend_rd;
   logic        e_stall, e_done;

   always @(negedge clk) begin
      if (m_valid) begin
         e_stall = (!m_busy && bus.start_e) || (m_busy && cyc < m_acc + m_lat);
         e_done  = m_busy && (cyc == m_acc + m_lat);
         if (e_done) begin
            m_res = m_pend;
            m_rd  = m_pend_rd;
         end
         check("stall_req", 32'(bus.stall_req), 32'(e_stall));
         check("done", 32'(bus.done), 32'(e_done));
         check("result", bus.result, m_res);
         check("rd_out", 32'(bus.rd_out), 32'(m_rd));
      end
      if (!reset_n) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_res   = '0;
         m_rd    = '0;
      end else if (m_valid) begin
         if (m_busy && cyc >= m_acc + m_lat)
            m_busy = 1'b0;
         else if (m_busy && bus.flush_e)
            m_busy = 1'b0;
         else if (!m_busy && bus.start_e && !bus.flush_e) begin
            m_busy    = 1'b1;
            m_acc     = cyc;
            m_lat     = ref_latency(bus.funct3_e, bus.src_a_e, bus.src_b_e);
            m_pend    = ref_result(bus.funct3_e, bus.src_a_e, bus.src_b_e);
            m_pend_rd = bus.rd_e;
         end
      end
   end

   // Holds start_e through DONE like the stalled E stage, then releases it.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_r, input int exp_lat,
                         output int done_cyc);
      int  t0;
      bit  seen;
      bus.start_e  = 1'b1;
      bus.funct3_e = f;
      bus.src_a_e  = a;
      bus.src_b_e  = b;
      bus.rd_e     = rd;
      t0           = cyc;
      seen         = 1'b0;
      done_cyc     = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen     = 1'b1;
            done_cyc = cyc;
            check("op_latency", 32'(cyc - t0), 32'(exp_lat));
            check("op_result", bus.result, exp_r);
            check("op_rd_out", 32'(bus.rd_out), 32'(rd));
         end
      end
      if (!seen) check("op_done_timeout", 32'(0), 32'(1));
      @(posedge clk);
      #1;
      bus.start_e = 1'b0;
   endtask

   task automatic start_only(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
      bus.start_e  = 1'b1;
      bus.funct3_e = f;
      bus.src_a_e  = a;
      bus.src_b_e  = b;
      bus.rd_e     = rd;
   endtask

   initial begin
      int dc, t0, pulses;
      reset_n      = 1'b0;
      bus.start_e  = 1'b0;
      bus.flush_e  = 1'b0;
      bus.funct3_e = '0;
      bus.src_a_e  = '0;
      bus.src_b_e  = '0;
      bus.rd_e     = '0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("reset_stall", 32'(bus.stall_req), 32'(0));
      check("reset_done", 32'(bus.done), 32'(0));
      check("reset_result", bus.result, 32'h0);
      @(posedge clk);
      #1;

      // Cycle-exact MUL: stall through cycle 33, done in 34.
      start_only(F3_MUL, 32'h7, 32'hFFFF_FFFD, 5'd5);
      t0 = cyc;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         check("mul_stall_window", 32'(bus.stall_req), 32'(1));
      end
      @(negedge clk);
      check("mul_done_c34", 32'(bus.done), 32'(1));
      check("mul_stall_c34", 32'(bus.stall_req), 32'(0));
      check("mul_result", bus.result, 32'hFFFF_FFEB);
      check("mul_rd", 32'(bus.rd_out), 32'(5));
      check("mul_cycle", 32'(cyc - t0), 32'(34));
      @(posedge clk);
      #1 bus.start_e = 1'b0;

      run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 34, dc);
      run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 34, dc);
      run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34, dc);
      run_op(F3_MULHU,  32'h0001_0000, 32'h0001_0000, 5'd9,  32'h0000_0001, 34, dc);
      run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 34, dc);
      run_op(F3_DIV,    32'hFFFF_FFF9, 32'h2,         5'd11, 32'hFFFF_FFFD, 34, dc);
      run_op(F3_REM,    32'hFFFF_FFF9, 32'h2,         5'd12, 32'hFFFF_FFFF, 34, dc);
      run_op(F3_DIV,    32'h7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34, dc);
      run_op(F3_REM,    32'h7,         32'hFFFF_FFFE, 5'd14, 32'h0000_0001, 34, dc);
      run_op(F3_DIVU,   32'd100,       32'd7,         5'd15, 32'd14,        34, dc);
      run_op(F3_REMU,   32'd100,       32'd7,         5'd16, 32'd2,         34, dc);
      run_op(F3_DIVU,   32'hFFFF_FFFF, 32'h1,         5'd17, 32'hFFFF_FFFF, 34, dc);
      run_op(F3_DIVU,   32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1,  dc);
      run_op(F3_REM,    32'd5,         32'd0,         5'd19, 32'd5,         1,  dc);
      run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1,  dc);
      run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0000_0000, 1,  dc);
      run_op(F3_REMU,   32'd0,         32'd3,         5'd22, 32'd0,         34, dc);

      // Flush at cycle 10 of a DIV, then leave the unit idle.
      start_only(F3_DIV, 32'd100, 32'd7, 5'd23);
      t0 = cyc;
      repeat (10) @(posedge clk);
      #1 bus.flush_e = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_e = 1'b0;
      bus.start_e = 1'b0;
      @(negedge clk);
      check("flush_idle_stall", 32'(bus.stall_req), 32'(0));
      check("flush_cycle", 32'(cyc - t0), 32'(11));
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) pulses++;
      end
      check("flush_no_done", 32'(pulses), 32'(0));
      check("flush_result_held", bus.result, 32'd0);
      @(posedge clk);
      #1;

      // Flush at cycle 10, new MUL accepted in cycle 11 finishes in cycle 45.
      start_only(F3_DIV, 32'd100, 32'd7, 5'd24);
      t0 = cyc;
      repeat (10) @(posedge clk);
      #1 bus.flush_e = 1'b1;
      @(posedge clk);
      #1 bus.flush_e = 1'b0;
      run_op(F3_MUL, 32'd3, 32'd5, 5'd25, 32'd15, 34, dc);
      check("flush_then_mul_cycle", 32'(dc - t0), 32'(45));

      // Reset in cycle 20 of a DIV.
      start_only(F3_DIV, 32'd1000, 32'd3, 5'd26);
      repeat (20) @(posedge clk);
      #1;
      reset_n     = 1'b0;
      bus.start_e = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_mid_stall", 32'(bus.stall_req), 32'(0));
      check("rst_mid_done", 32'(bus.done), 32'(0));
      check("rst_mid_result", bus.result, 32'h0);
      check("rst_mid_rd", 32'(bus.rd_out), 32'(0));
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1;
      run_op(F3_DIV, 32'd1000, 32'd3, 5'd27, 32'd333, 34, dc);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It accepts one M-extension op per request and runs a 32-step shift-add or shift-subtract sequence. While the op is in flight it drives a stall request into the hazard unit. When the result is ready, that result is presented for the E→M pipeline register.

## Interface

- XLEN, 32, operand/result width; counter width is clog2(XLEN)+1
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- start_e  input  1  valid M-op currently in execute
- funct3_e  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- src_a_e  input  XLEN  forwarded rs1 operand
- src_b_e  input  XLEN  forwarded rs2 operand
- rd_e  input  5  destination register
- flush_e  input  1  kill in-flight op
- stall_req  output  1  combinational; OR into stall_f/stall_d and hold of the E stage
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  op result, held until next accepted start
- rd_out  output  5  rd of the completed op

## Operation

- FSM states, kept in `muldiv_pkg`:
  - IDLE → CALC when start_e is high and the op is not special.
  - IDLE → DONE when start_e is high and the op is special.
  - CALC → FIXUP when step count reaches XLEN.
  - FIXUP → DONE unconditionally.
  - DONE → IDLE unconditionally.
- On accept in IDLE:
  - Latch funct3_e and rd_e.
  - Latch operand magnitudes (two's-complement absolute value where the operand is signed).
  - Latch the negate flags:
    - quotient/product: sign_a XOR sign_b
    - remainder: sign_a
  - Signedness: MULH/DIV/REM treat both operands as signed. MULHSU treats a as signed, b as unsigned. MULHU/DIVU/REMU and MUL treat both as unsigned, since MUL uses the low word only.
- Multiply uses a 2·XLEN accumulator with radix-2 shift-add, one bit per cycle.
  - MUL returns the low word.
  - MULH/MULHSU/MULHU return the high word after sign fixup.
- Divide uses restoring shift-subtract with one quotient bit per cycle. The remainder register is XLEN+1 bits.
- Special cases are detected in IDLE, take no CALC cycles, and go straight to DONE:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give src_a.
  - Signed overflow (0x80000000 / −1): DIV gives 0x80000000; REM gives 0.
- FIXUP conditionally negates the selected half, quotient or remainder.
- stall_req = (IDLE & start_e) | CALC | FIXUP.
  - It is low in DONE, so the pipeline advances the op in that cycle.
  - start_e seen in DONE belongs to the same instruction and is ignored.
- flush_e has priority over every transition, including start_e in IDLE:
  - Next state is IDLE.
  - done is not asserted.
  - result and rd_out keep their previous values.

## Timing

- Reset (reset_n low at a clock edge):
  - State → IDLE, counter → 0, done → 0, result → 0, rd_out → 0.
  - stall_req is 0 while in IDLE with start_e low.
- Reset mid-operation aborts the op exactly as flush_e does, and also clears result and rd_out.
- Normal op with start accepted in cycle 0:
  - CALC occupies cycles 1..32; FIXUP is cycle 33; DONE is cycle 34.
  - stall_req is high in cycles 0..33; done pulses in cycle 34.
  - Total latency is XLEN+2 cycles.
- Special op: stall_req high in cycle 0; done and the result in cycle 1.
- result and rd_out are registered and become valid in the DONE cycle.
- Back-to-back ops: a new start_e is first accepted in the IDLE cycle that follows DONE, with no extra bubble beyond the pipeline advance.
- flush_e in cycle k: state is IDLE in cycle k+1, where a new start is accepted if present.
- Counter wrap: the counter resets to 0 on accept and never wraps within an op.

## Structure

- `muldiv_pkg` holds:
  - the state enum (IDLE, CALC, FIXUP, DONE)
  - the funct3 encodings
  - the XLEN default
- Sub-module `muldiv_datapath` holds the accumulator, remainder and operand registers, one shift-add/shift-subtract step per enable, and the fixup negation.
- The top level holds the FSM, step counter, special-case detection, stall_req and done.

## Test plan

- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), start in cycle 0 → stall_req high cycles 0–33, done in cycle 34, result 0xFFFFFFEB, rd_out equals the latched rd_e.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH −1 × −1 → 0x00000000. MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 % 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 % 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF with done in cycle 1. REM 5 % 0 → 5. DIV 0x80000000 / −1 → 0x80000000 and REM → 0, both with done in cycle 1.
- DIV started in cycle 0 with flush_e in cycle 10 → IDLE in cycle 11, no done pulse, stall_req low. A MUL started in cycle 11 completes in cycle 45.
- reset_n low in cycle 20 of a DIV → the next cycle shows IDLE, result 0, done 0. A held start_e during DONE does not retrigger the op.
